// File: rtl/rx_iq_scheduler.sv
// rx_iq_scheduler: merges the RX1/RX2 I/Q sample streams into one FIFO.
// Each receiver strobe is held in a pending register. A two-slot writer
// moves pending samples into the FIFO, alternating RX1/RX2 while dual
// receive is enabled. The bus side pops one entry per READ_CLK rising
// edge that arrives while READ_REQ is high.
//
// Ports:
//   clk_in, reset            system clock, synchronous active-high reset
//   RX1_I/Q, RX1_valid       RX1 sample and its one-cycle strobe
//   RX2_I/Q, RX2_valid       RX2 sample and its strobe (used only when
//                            rx2_enable is high)
//   rx2_enable               dual-receiver mode
//   IQ_RX_READ_REQ/CLK       bus read request level and read clock level
//   flags_clear              one-cycle clear of the sticky flags
//   IQ_I/Q, IQ_SRC           last popped sample and its source (1 = RX2)
//   in_empty, fill_level     registered FIFO status
//   iq_overrun, iq_underrun  sticky error flags

module rx_iq_scheduler #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic [23:0]              RX1_I,
    input  logic [23:0]              RX1_Q,
    input  logic                     RX1_valid,
    input  logic [23:0]              RX2_I,
    input  logic [23:0]              RX2_Q,
    input  logic                     RX2_valid,
    input  logic                     rx2_enable,
    input  logic                     IQ_RX_READ_REQ,
    input  logic                     IQ_RX_READ_CLK,
    input  logic                     flags_clear,
    output logic [23:0]              IQ_I,
    output logic [23:0]              IQ_Q,
    output logic                     IQ_SRC,
    output logic                     in_empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     iq_overrun,
    output logic                     iq_underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        SLOT_RX1 = 1'b0,
        SLOT_RX2 = 1'b1
    } slot_e;

    typedef struct packed {
        logic        src;
        logic [23:0] i;
        logic [23:0] q;
    } entry_t;

    // Sample storage
    entry_t          mem_q [DEPTH];

    // Registered state
    slot_e           slot_q, slot_d;
    logic            pend1_q, pend1_d;
    logic            pend2_q, pend2_d;
    logic [47:0]     p1_q, p1_d;
    logic [47:0]     p2_q, p2_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            empty_q, empty_d;
    entry_t          out_q, out_d;
    logic            ovr_q, ovr_d;
    logic            und_q, und_d;
    logic            rclk_prev_q, rclk_prev_d;

    // Combinational controls
    logic            pop_evt;
    logic            full;
    logic            fifo_empty;
    logic            wr_en;
    logic            rd_en;
    logic            wr1;
    logic            wr2;
    logic            ovr_set;
    logic            und_set;
    entry_t          wr_data;

    assign pop_evt    = IQ_RX_READ_CLK & ~rclk_prev_q & IQ_RX_READ_REQ;
    // Full is judged on the pre-pop count: a same-cycle pop never
    // frees a slot for a same-cycle write.
    assign full       = (cnt_q == CW'(DEPTH));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        slot_d      = slot_q;
        pend1_d     = pend1_q;
        pend2_d     = pend2_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        rclk_prev_d = IQ_RX_READ_CLK;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr1         = 1'b0;
        wr2         = 1'b0;
        ovr_set     = 1'b0;
        und_set     = 1'b0;
        wr_data     = '0;

        // Writer slot machine
        case (slot_q)
            SLOT_RX1: begin
                if (pend1_q && !full) begin
                    wr_en   = 1'b1;
                    wr1     = 1'b1;
                    wr_data = {1'b0, p1_q};
                    pend1_d = 1'b0;
                    slot_d  = rx2_enable ? SLOT_RX2 : SLOT_RX1;
                end
            end
            SLOT_RX2: begin
                if (!rx2_enable) begin
                    // Dual mode dropped: discard any RX2 leftover
                    pend2_d = 1'b0;
                    slot_d  = SLOT_RX1;
                end else if (pend2_q && !full) begin
                    wr_en   = 1'b1;
                    wr2     = 1'b1;
                    wr_data = {1'b1, p2_q};
                    pend2_d = 1'b0;
                    slot_d  = SLOT_RX1;
                end
            end
        endcase

        // Capture after the write decision, so a strobe landing on the
        // cycle its receiver is written re-arms pend without overrun.
        if (RX1_valid) begin
            if (pend1_q && !wr1) begin
                ovr_set = 1'b1;
            end
            pend1_d = 1'b1;
            p1_d    = {RX1_I, RX1_Q};
        end

        if (RX2_valid && rx2_enable) begin
            if (pend2_q && !wr2) begin
                ovr_set = 1'b1;
            end
            pend2_d = 1'b1;
            p2_d    = {RX2_I, RX2_Q};
        end

        // Read side
        if (pop_evt) begin
            if (!fifo_empty) begin
                rd_en    = 1'b1;
                out_d    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                und_set  = 1'b1;
            end
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        empty_d = (cnt_d == '0);

        // A set in the same cycle wins over flags_clear
        ovr_d = (ovr_q & ~flags_clear) | ovr_set;
        und_d = (und_q & ~flags_clear) | und_set;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            slot_q      <= SLOT_RX1;
            pend1_q     <= 1'b0;
            pend2_q     <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            out_q       <= '0;
            ovr_q       <= 1'b0;
            und_q       <= 1'b0;
            rclk_prev_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            pend1_q     <= pend1_d;
            pend2_q     <= pend2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            empty_q     <= empty_d;
            out_q       <= out_d;
            ovr_q       <= ovr_d;
            und_q       <= und_d;
            rclk_prev_q <= rclk_prev_d;
        end
    end

    // Storage array: pointers are reset, contents need not be
    always_ff @(posedge clk_in) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign IQ_I        = out_q.i;
    assign IQ_Q        = out_q.q;
    assign IQ_SRC      = out_q.src;
    assign in_empty    = empty_q;
    assign fill_level  = cnt_q;
    assign iq_overrun  = ovr_q;
    assign iq_underrun = und_q;

endmodule
